ldm_stm_sequencer: RTL and testbench
====================================

// Module: ldm_stm_sequencer
// PURPOSE
//  Initiator side of the 16-entry register-file port: walks a 16-bit register list and
//  issues register reads/writes plus word memory accesses for block load/store (LDM/STM,
//  increment-after). Sits between control unit and register file/data memory; stalls core via busy.
// PARAMETERS
//  NREGS      16  number of architectural registers (register-list width)
//  RAW        4   register index width, log2(NREGS)
//  DW         32  data and address width
//  ADDR_STEP  4   byte increment per transferred word
// PORTS
//  clk           in   1     single clock, all state on posedge
//  rst           in   1     synchronous, active-high reset
//  start         in   1     1-cycle request; sampled only in IDLE
//  is_load       in   1     1 = LDM (mem->reg), 0 = STM (reg->mem)
//  reg_list      in   NREGS register bitmap, bit i = register i
//  base_addr     in   DW    start byte address
//  base_reg      in   RAW   base register index (writeback target)
//  wb_req        in   1     request base writeback (used only with LDM_STM_WB_EN)
//  busy          out  1     high from accepted start until done cycle inclusive
//  done          out  1     1-cycle pulse, transfer complete
//  rf_read_reg   out  RAW   register-file read index
//  rf_read_data  in   DW    register-file read data, combinational from rf_read_reg
//  rf_write_reg  out  RAW   register-file write index
//  rf_write_data out  DW    register-file write data
//  rf_reg_write  out  1     register-file write enable (file commits on negedge)
//  mem_addr      out  DW    word address
//  mem_wdata     out  DW    store data
//  mem_write     out  1     store strobe
//  mem_read      out  1     load strobe; mem_rdata valid the following cycle
//  mem_rdata     in   DW    load data
// BEHAVIOUR
//  - Reset: state IDLE; busy, done, rf_reg_write, mem_write, mem_read = 0; all index/addr/data outputs = 0.
//  - States: IDLE, XFER, LOAD_WB, BASE_WB, DONE.
//  - IDLE: start=1 latches is_load, reg_list (as pending), base_addr, base_reg, wb_req; addr <= base_addr,
//    count <= 0. Empty list -> DONE directly (no mem/rf strobes); else -> XFER. start outside IDLE ignored.
//  - Order: lowest set pending bit first (ascending index); address of k-th transfer = base_addr + ADDR_STEP*k.
//  - XFER/STM: rf_read_reg = cur idx, mem_addr = addr, mem_wdata = rf_read_data, mem_write=1 for one cycle;
//    clear bit, addr += ADDR_STEP. 1 cycle/register. Next: XFER if bits remain, else BASE_WB or DONE.
//  - XFER/LDM: mem_read=1, mem_addr = addr (1 cycle) -> LOAD_WB: rf_write_reg = cur idx,
//    rf_write_data = mem_rdata, rf_reg_write=1 (1 cycle); clear bit, addr += ADDR_STEP. 2 cycles/register.
//  - Address arithmetic modulo 2^DW (wraps silently). At most one strobe active per cycle.
//  - DONE: done=1, busy=1 for one cycle -> IDLE. start in DONE cycle ignored.
//  - rst mid-operation: abort at next posedge, pending list discarded, no further strobes.
//  - Latency start->done: STM N+1 cycles, LDM 2N+1, empty list 1 (N = popcount(reg_list)).
// CONFIGURATION
//  - LDM_STM_WB_EN defined: after last transfer, if latched wb_req=1 enter BASE_WB for one cycle:
//    rf_write_reg = base_reg, rf_write_data = base_addr + ADDR_STEP*N, rf_reg_write=1; skipped (direct to
//    DONE) when LDM list contains base_reg (loaded value wins) or list empty.
//  - Undefined: BASE_WB state absent, wb_req ignored, base_reg unused; latencies as above.
// STRUCTURE
//  - Shared package/include: state encodings, ADDR_STEP, RAW/DW defaults, register count.
//  - Sub-module reg_list_pri_enc: combinational lowest-set-bit index + any-set flag over NREGS bits.
//  - Top: FSM, pending-list register, address/count registers, output muxing.
// TESTING
//  - STM list 16'h0013, base 32'h100: mem_write at 0x100/0x104/0x108 with r0,r1,r4 data; done at cycle 4.
//  - LDM list 16'h8001, base 32'h200: mem_read 0x200, 0x204; r0, r15 written with returned words; done cycle 5.
//  - Empty list start: done pulse next cycle, zero mem/rf strobes; start while busy has no effect.
//  - WB_EN, STM r2..r3 base_reg=r5 wb_req=1, base 0x40: r5 <= 0x48 after stores; LDM incl. base_reg: no BASE_WB.
//  - base 32'hFFFF_FFFC, list 16'h0003: second address wraps to 0x0000_0000.
//  - rst asserted during LDM LOAD_WB: next cycle IDLE, all strobes 0, busy 0, no done pulse.

Source files
------------

// File: rtl/ldm_stm_sequencer_pkg.sv
// Shared constants, FSM encoding and address helper for the LDM/STM sequencer.
// StBaseWb exists only when LDM_STM_WB_EN is defined.
package ldm_stm_sequencer_pkg;

  localparam int unsigned NREGS     = 16;
  localparam int unsigned RAW       = 4;
  localparam int unsigned DW        = 32;
  localparam int unsigned ADDR_STEP = 4;

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StXfer   = 3'd1,
    StLoadWb = 3'd2,
`ifdef LDM_STM_WB_EN
    StBaseWb = 3'd4,
`endif
    StDone   = 3'd3
  } state_e;

  // Byte address of the k-th transfer; wraps modulo 2^DW.
  function automatic logic [DW-1:0] addr_at(input logic [DW-1:0] base, input logic [RAW:0] k);
    return base + DW'(ADDR_STEP) * DW'(k);
  endfunction

endpackage

// File: rtl/ldm_stm_sequencer_if.sv
// Control, register-file and data-memory signals of the LDM/STM sequencer.
// master = sequencer side, slave = control unit / register file / memory side.
interface ldm_stm_sequencer_if;
  import ldm_stm_sequencer_pkg::*;

  logic             start;
  logic             is_load;
  logic [NREGS-1:0] reg_list;
  logic [DW-1:0]    base_addr;
  logic [RAW-1:0]   base_reg;
  logic             wb_req;
  logic             busy;
  logic             done;
  logic [RAW-1:0]   rf_read_reg;
  logic [DW-1:0]    rf_read_data;
  logic [RAW-1:0]   rf_write_reg;
  logic [DW-1:0]    rf_write_data;
  logic             rf_reg_write;
  logic [DW-1:0]    mem_addr;
  logic [DW-1:0]    mem_wdata;
  logic             mem_write;
  logic             mem_read;
  logic [DW-1:0]    mem_rdata;

  modport master (
    input  start, is_load, reg_list, base_addr, base_reg, wb_req, rf_read_data, mem_rdata,
    output busy, done, rf_read_reg, rf_write_reg, rf_write_data, rf_reg_write,
           mem_addr, mem_wdata, mem_write, mem_read
  );

  modport slave (
    output start, is_load, reg_list, base_addr, base_reg, wb_req, rf_read_data, mem_rdata,
    input  busy, done, rf_read_reg, rf_write_reg, rf_write_data, rf_reg_write,
           mem_addr, mem_wdata, mem_write, mem_read
  );

endinterface

// File: rtl/ldm_stm_sequencer_reg_list_pri_enc.sv
// Lowest-set-bit index and any-set flag over a register bitmap (reg_list_pri_enc).
module ldm_stm_sequencer_reg_list_pri_enc #(
  parameter int unsigned NREGS = 16,
  parameter int unsigned RAW   = 4
) (
  input  logic [NREGS-1:0] i_list,
  output logic [RAW-1:0]   o_idx,
  output logic             o_any
);

  // Descending scan so the lowest set bit is the last one to assign.
  always_comb begin
    o_idx = '0;
    for (int i = NREGS - 1; i >= 0; i--) begin
      if (i_list[i]) o_idx = RAW'(i);
    end
  end

  assign o_any = |i_list;

endmodule

// File: rtl/ldm_stm_sequencer.sv
// LDM/STM block-transfer sequencer: walks a register list, ascending, increment-after.
// Optional base-register writeback is built when LDM_STM_WB_EN is defined.
module ldm_stm_sequencer
  import ldm_stm_sequencer_pkg::*;
(
  input logic           i_clk,
  input logic           i_rst,
  ldm_stm_sequencer_if.master io_bus
);

  state_e           r_state, w_state_d, w_after;
  logic [NREGS-1:0] r_pending, w_pending_clr;
  logic             r_is_load;
  logic [DW-1:0]    r_base, w_addr;
  logic [RAW:0]     r_count;
  logic [RAW-1:0]   w_idx;
  logic             w_any, w_step, w_accept;

  ldm_stm_sequencer_reg_list_pri_enc #(
    .NREGS (NREGS),
    .RAW   (RAW)
  ) u_pri_enc (
    .i_list (r_pending),
    .o_idx  (w_idx),
    .o_any  (w_any)
  );

  assign w_accept      = (r_state == StIdle) && io_bus.start;
  assign w_pending_clr = r_pending & ~(NREGS'(1) << w_idx);
  assign w_addr        = addr_at(r_base, r_count);
  assign w_step        = w_any && (((r_state == StXfer) && !r_is_load) || (r_state == StLoadWb));

`ifdef LDM_STM_WB_EN
  logic           r_wb_go;
  logic [RAW-1:0] r_base_reg;

  // A loaded base register keeps the loaded value, so writeback is dropped.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wb_go    <= 1'b0;
      r_base_reg <= '0;
    end else if (w_accept) begin
      r_wb_go    <= io_bus.wb_req && (|io_bus.reg_list) &&
                    !(io_bus.is_load && io_bus.reg_list[io_bus.base_reg]);
      r_base_reg <= io_bus.base_reg;
    end
  end

  assign w_after = r_wb_go ? StBaseWb : StDone;
`else
  logic w_unused_wb;
  assign w_unused_wb = ^{io_bus.base_reg, io_bus.wb_req};
  assign w_after     = StDone;
`endif

  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= StIdle;
    else       r_state <= w_state_d;
  end

  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      StIdle: begin
        if (io_bus.start) w_state_d = (|io_bus.reg_list) ? StXfer : StDone;
      end
      StXfer: begin
        if (!w_any)                 w_state_d = w_after;
        else if (r_is_load)         w_state_d = StLoadWb;
        else if (|w_pending_clr)    w_state_d = StXfer;
        else                        w_state_d = w_after;
      end
      StLoadWb: w_state_d = (|w_pending_clr) ? StXfer : w_after;
`ifdef LDM_STM_WB_EN
      StBaseWb: w_state_d = StDone;
`endif
      StDone:   w_state_d = StIdle;
      default:  w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_pending <= '0;
      r_is_load <= 1'b0;
      r_base    <= '0;
      r_count   <= '0;
    end else if (w_accept) begin
      r_pending <= io_bus.reg_list;
      r_is_load <= io_bus.is_load;
      r_base    <= io_bus.base_addr;
      r_count   <= '0;
    end else if (w_step) begin
      r_pending <= w_pending_clr;
      r_count   <= r_count + 1'b1;
    end
  end

  always_comb begin
    io_bus.busy          = (r_state != StIdle);
    io_bus.done          = 1'b0;
    io_bus.rf_read_reg   = '0;
    io_bus.rf_write_reg  = '0;
    io_bus.rf_write_data = '0;
    io_bus.rf_reg_write  = 1'b0;
    io_bus.mem_addr      = '0;
    io_bus.mem_wdata     = '0;
    io_bus.mem_write     = 1'b0;
    io_bus.mem_read      = 1'b0;
    unique case (r_state)
      StXfer: begin
        io_bus.mem_addr = w_addr;
        if (r_is_load) begin
          io_bus.mem_read = 1'b1;
        end else begin
          io_bus.rf_read_reg = w_idx;
          io_bus.mem_wdata   = io_bus.rf_read_data;
          io_bus.mem_write   = 1'b1;
        end
      end
      StLoadWb: begin
        io_bus.rf_write_reg  = w_idx;
        io_bus.rf_write_data = io_bus.mem_rdata;
        io_bus.rf_reg_write  = 1'b1;
      end
`ifdef LDM_STM_WB_EN
      StBaseWb: begin
        io_bus.rf_write_reg  = r_base_reg;
        io_bus.rf_write_data = w_addr;
        io_bus.rf_reg_write  = 1'b1;
      end
`endif
      StDone:  io_bus.done = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_ldm_stm_sequencer.sv
// Self-checking bench for ldm_stm_sequencer: vector table, event scoreboard, rst corner case.
// Expected BASE_WB events are generated only when LDM_STM_WB_EN is defined.
module tb_ldm_stm_sequencer;
  import ldm_stm_sequencer_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ldm_stm_sequencer_if bus ();

  ldm_stm_sequencer dut (
    .i_clk  (clk),
    .i_rst  (rst),
    .io_bus (bus)
  );

  typedef struct {
    logic        is_load;
    logic [15:0] list;
    logic [31:0] base;
    logic [3:0]  breg;
    logic        wb;
    int          lat;   // start -> done cycles, without base writeback
    int          poke;  // relative cycle to re-pulse start, -1 = none
  } vec_t;

  // kind: 0 mem_write, 1 mem_read, 2 rf write, 3 done (d carries busy)
  typedef struct {
    int          kind;
    logic [31:0] a;
    logic [31:0] d;
    int          cyc;
  } ev_t;

  ev_t         sbq[$];
  int          checks = 0;
  int          errors = 0;
  int          gcyc   = 0;
  int          t0     = 0;
  bit          sb_on  = 1'b0;
  logic [31:0] rf[16];
  vec_t        vecs[9];

  function automatic logic [31:0] memfn(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h5A5A_0F0F;
  endfunction

  always @(posedge clk) gcyc <= gcyc + 1;

  always @(posedge clk) if (bus.mem_read) bus.mem_rdata <= memfn(bus.mem_addr);

  assign bus.rf_read_data = rf[bus.rf_read_reg];

  always @(negedge clk) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) rf[i] <= 32'hC0DE_0000 + i * 32'h0001_0101;
    end else if (bus.rf_reg_write) begin
      rf[bus.rf_write_reg] <= bus.rf_write_data;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  task automatic sb_check(input int kind, input logic [31:0] a, input logic [31:0] d);
    int  rel;
    ev_t e;
    rel = gcyc - t0;
    checks++;
    if (sbq.size() == 0) begin
      errors++;
      $display("FAIL unexpected_event: got kind=%0d a=%h d=%h cyc=%0d, required no event",
               kind, a, d, rel);
    end else begin
      e = sbq.pop_front();
      if (e.kind != kind || e.a !== a || e.d !== d || e.cyc != rel) begin
        errors++;
        $display("FAIL event: got kind=%0d a=%h d=%h cyc=%0d, required kind=%0d a=%h d=%h cyc=%0d",
                 kind, a, d, rel, e.kind, e.a, e.d, e.cyc);
      end
    end
  endtask

  always @(negedge clk) begin
    if (sb_on) begin
      if (int'(bus.mem_write) + int'(bus.mem_read) + int'(bus.rf_reg_write) > 1) begin
        checks++;
        errors++;
        $display("FAIL one_strobe: got wr=%b rd=%b rfw=%b, required at most one",
                 bus.mem_write, bus.mem_read, bus.rf_reg_write);
      end
      if (bus.mem_write)    sb_check(0, bus.mem_addr, bus.mem_wdata);
      if (bus.mem_read)     sb_check(1, bus.mem_addr, 32'h0);
      if (bus.rf_reg_write) sb_check(2, 32'(bus.rf_write_reg), bus.rf_write_data);
      if (bus.done)         sb_check(3, 32'h0, {31'h0, bus.busy});
    end
  end

  task automatic gen(input vec_t v);
    int          k;
    int          ex;
    logic [31:0] addr;
    k  = 0;
    ex = 0;
    for (int i = 0; i < 16; i++) begin
      if (v.list[i]) begin
        addr = v.base + 32'(4 * k);
        if (v.is_load) begin
          sbq.push_back(ev_t'{1, addr, 32'h0, 1 + 2 * k});
          sbq.push_back(ev_t'{2, 32'(i), memfn(addr), 2 + 2 * k});
        end else begin
          sbq.push_back(ev_t'{0, addr, rf[i], 1 + k});
        end
        k++;
      end
    end
`ifdef LDM_STM_WB_EN
    if (v.wb && k > 0 && !(v.is_load && v.list[v.breg])) begin
      sbq.push_back(ev_t'{2, 32'(v.breg), v.base + 32'(4 * k), v.lat});
      ex = 1;
    end
`endif
    sbq.push_back(ev_t'{3, 32'h0, 32'h1, v.lat + ex});
  endtask

  task automatic run_op(input vec_t v, input string name);
    int rel;
    gen(v);
    @(posedge clk); #2;
    t0            = gcyc;
    bus.is_load   = v.is_load;
    bus.reg_list  = v.list;
    bus.base_addr = v.base;
    bus.base_reg  = v.breg;
    bus.wb_req    = v.wb;
    bus.start     = 1'b1;
    for (int c = 0; c < 80 && sbq.size() > 0; c++) begin
      @(posedge clk); #2;
      rel = gcyc - t0;
      if (rel == v.poke) begin
        bus.start    = 1'b1;
        bus.reg_list = 16'hFFFF;
        bus.is_load  = ~v.is_load;
      end else begin
        bus.start = 1'b0;
      end
    end
    bus.start = 1'b0;
    checks++;
    if (sbq.size() != 0) begin
      errors++;
      $display("FAIL %s timeout: got %0d events outstanding, required 0", name, sbq.size());
      sbq.delete();
    end
    @(negedge clk);
    chk({name, "_idle_after"}, {30'h0, bus.busy, bus.done}, 32'h0);
    repeat (3) @(negedge clk);
  endtask

  initial begin
    logic bad;
    vecs[0] = vec_t'{1'b0, 16'h0013, 32'h0000_0100, 4'd0,  1'b0, 4,  -1};
    vecs[1] = vec_t'{1'b1, 16'h8001, 32'h0000_0200, 4'd0,  1'b0, 5,  -1};
    vecs[2] = vec_t'{1'b0, 16'h0000, 32'h0000_0300, 4'd0,  1'b0, 1,  1};
    vecs[3] = vec_t'{1'b0, 16'h000C, 32'h0000_0040, 4'd5,  1'b1, 3,  2};
    vecs[4] = vec_t'{1'b1, 16'h0021, 32'h0000_0500, 4'd5,  1'b1, 5,  -1};
    vecs[5] = vec_t'{1'b0, 16'h0003, 32'hFFFF_FFFC, 4'd0,  1'b0, 3,  -1};
    vecs[6] = vec_t'{1'b1, 16'hA5A5, 32'h0000_1000, 4'd3,  1'b1, 17, 4};
    vecs[7] = vec_t'{1'b0, 16'hFFFF, 32'h0000_2000, 4'd15, 1'b1, 17, -1};
    vecs[8] = vec_t'{1'b1, 16'h0000, 32'h0000_3000, 4'd2,  1'b1, 1,  -1};

    bus.start     = 1'b0;
    bus.is_load   = 1'b0;
    bus.reg_list  = '0;
    bus.base_addr = '0;
    bus.base_reg  = '0;
    bus.wb_req    = 1'b0;
    rst           = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    chk("rst_busy",       {31'h0, bus.busy},         32'h0);
    chk("rst_done",       {31'h0, bus.done},         32'h0);
    chk("rst_strobes",    {29'h0, bus.mem_write, bus.mem_read, bus.rf_reg_write}, 32'h0);
    chk("rst_mem_addr",   bus.mem_addr,              32'h0);
    chk("rst_mem_wdata",  bus.mem_wdata,             32'h0);
    chk("rst_rf_idx",     {24'h0, bus.rf_read_reg, bus.rf_write_reg}, 32'h0);
    chk("rst_rf_wdata",   bus.rf_write_data,         32'h0);
    rst   = 1'b0;
    sb_on = 1'b1;

    for (int i = 0; i < 9; i++) run_op(vecs[i], $sformatf("vec%0d", i));

    // rst while an LDM sits in LOAD_WB: abort with no further strobes or done
    sb_on = 1'b0;
    @(posedge clk); #2;
    bus.is_load   = 1'b1;
    bus.reg_list  = 16'h8001;
    bus.base_addr = 32'h0000_0300;
    bus.wb_req    = 1'b0;
    bus.start     = 1'b1;
    @(posedge clk); #2;
    bus.start = 1'b0;
    chk("rstmid_xfer_read", {31'h0, bus.mem_read}, 32'h1);
    @(posedge clk); #2;
    chk("rstmid_loadwb",    {31'h0, bus.rf_reg_write}, 32'h1);
    rst = 1'b1;
    @(posedge clk); #2;
    rst = 1'b0;
    chk("rstmid_idle", {27'h0, bus.busy, bus.done, bus.mem_write, bus.mem_read,
                        bus.rf_reg_write}, 32'h0);
    bad = 1'b0;
    repeat (5) begin
      @(negedge clk);
      if (bus.busy || bus.done || bus.mem_write || bus.mem_read || bus.rf_reg_write) bad = 1'b1;
    end
    chk("rstmid_quiet", {31'h0, bad}, 32'h0);
    sb_on = 1'b1;
    run_op(vec_t'{1'b1, 16'h0006, 32'h0000_0080, 4'd0, 1'b0, 5, -1}, "post_rst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
